// File: rtl/capture_readout.sv
// capture_readout: streams the sample RAM to the UART TX, two bytes per sample.
// Optional trailing XOR checksum byte when CAPTURE_READOUT_CHECKSUM_EN is defined.
module capture_readout #(
  parameter int ADDR_WIDTH = 9,
  parameter int DATA_WIDTH = 12
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_start,
  input  logic [ADDR_WIDTH-1:0] i_start_addr,
  output logic [ADDR_WIDTH-1:0] o_read_address,
  output logic                  o_read_en,
  input  logic [DATA_WIDTH-1:0] i_read_data,
  input  logic                  i_tx_ready,
  output logic [7:0]            o_tx_data,
  output logic                  o_tx_en,
  output logic                  o_busy,
  output logic                  o_done
);

  localparam int CW = ADDR_WIDTH + 1;
  localparam logic [CW-1:0] LAST = {1'b0, {ADDR_WIDTH{1'b1}}};

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_LATCH,
    S_SEND_HI,
    S_SEND_LO,
`ifdef CAPTURE_READOUT_CHECKSUM_EN
    S_CHK,
`endif
    S_DONE
  } state_t;

  state_t                  state;
  logic [ADDR_WIDTH-1:0]   addr;
  logic [CW-1:0]           sample_cnt;
  logic [DATA_WIDTH-1:0]   sample_q;
  logic [15:0]             sample_w;
  logic                    tx_ok;
`ifdef CAPTURE_READOUT_CHECKSUM_EN
  logic [7:0]              xor_q;
`endif

  // Sample zero-padded to two bytes; TX ready is blanked the cycle after a pulse
  assign sample_w = 16'(sample_q);
  assign tx_ok    = i_tx_ready && !o_tx_en;

  // Readout sequencer with registered RAM and UART handshake outputs
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state          <= S_IDLE;
      addr           <= '0;
      sample_cnt     <= '0;
      sample_q       <= '0;
      o_read_address <= '0;
      o_read_en      <= 1'b0;
      o_tx_data      <= 8'h00;
      o_tx_en        <= 1'b0;
      o_busy         <= 1'b0;
      o_done         <= 1'b0;
`ifdef CAPTURE_READOUT_CHECKSUM_EN
      xor_q          <= 8'h00;
`endif
    end else begin
      o_read_en <= 1'b0;
      o_tx_en   <= 1'b0;
      o_done    <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (i_start) begin
            addr           <= i_start_addr;
            sample_cnt     <= '0;
            o_busy         <= 1'b1;
            o_read_en      <= 1'b1;
            o_read_address <= i_start_addr;
`ifdef CAPTURE_READOUT_CHECKSUM_EN
            xor_q          <= 8'h00;
`endif
            state          <= S_READ;
          end
        end
        S_READ: begin
          state <= S_LATCH;
        end
        S_LATCH: begin
          sample_q <= i_read_data;
          state    <= S_SEND_HI;
        end
        S_SEND_HI: begin
          if (tx_ok) begin
            o_tx_en   <= 1'b1;
            o_tx_data <= sample_w[15:8];
`ifdef CAPTURE_READOUT_CHECKSUM_EN
            xor_q     <= xor_q ^ sample_w[15:8];
`endif
            state     <= S_SEND_LO;
          end
        end
        S_SEND_LO: begin
          if (tx_ok) begin
            o_tx_en    <= 1'b1;
            o_tx_data  <= sample_w[7:0];
`ifdef CAPTURE_READOUT_CHECKSUM_EN
            xor_q      <= xor_q ^ sample_w[7:0];
`endif
            addr       <= addr + 1'b1;
            sample_cnt <= sample_cnt + 1'b1;
            if (sample_cnt == LAST) begin
`ifdef CAPTURE_READOUT_CHECKSUM_EN
              state  <= S_CHK;
`else
              o_done <= 1'b1;
              state  <= S_DONE;
`endif
            end else begin
              o_read_en      <= 1'b1;
              o_read_address <= addr + 1'b1;
              state          <= S_READ;
            end
          end
        end
`ifdef CAPTURE_READOUT_CHECKSUM_EN
        S_CHK: begin
          if (tx_ok) begin
            o_tx_en   <= 1'b1;
            o_tx_data <= xor_q;
            o_done    <= 1'b1;
            state     <= S_DONE;
          end
        end
`endif
        S_DONE: begin
          o_busy <= 1'b0;
          state  <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_capture_readout.sv
// tb_capture_readout: directed scenarios for the sample buffer readout.
// RAM model, byte monitor and optional 20-cycle TX backpressure.
module tb_capture_readout;

  localparam int AW    = 9;
  localparam int DW    = 12;
  localparam int DEPTH = 512;
`ifdef CAPTURE_READOUT_CHECKSUM_EN
  localparam int NB = 2 * DEPTH + 1;
`else
  localparam int NB = 2 * DEPTH;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [AW-1:0] start_addr = '0;
  logic [AW-1:0] read_address;
  logic          read_en;
  logic [DW-1:0] rdata = '0;
  logic          tx_ready;
  logic [7:0]    tx_data;
  logic          tx_en;
  logic          busy;
  logic          done;

  logic          tb_ready = 1'b0;
  logic          bp_mode = 1'b0;
  int            stall = 0;
  logic          ready_seen = 1'b0;
  logic          en_prev = 1'b0;

  logic [DW-1:0] ram [DEPTH];
  logic [7:0]    rx [$];
  int            ra [$];
  int            done_cnt = 0;
  int            viol = 0;
  int            dup = 0;
  int            chk_cnt = 0;
  int            pass_cnt = 0;

  assign tx_ready = bp_mode ? (stall == 0) : tb_ready;

  capture_readout #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .i_clk          (clk),
    .i_rst_n        (rst_n),
    .i_start        (start),
    .i_start_addr   (start_addr),
    .o_read_address (read_address),
    .o_read_en      (read_en),
    .i_read_data    (rdata),
    .i_tx_ready     (tx_ready),
    .o_tx_data      (tx_data),
    .o_tx_en        (tx_en),
    .o_busy         (busy),
    .o_done         (done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (read_en) rdata <= ram[read_address];
    ready_seen <= tx_ready;
  end

  always @(negedge clk) begin
    if (tx_en) begin
      rx.push_back(tx_data);
      if (!ready_seen) viol++;
      if (en_prev) dup++;
    end
    en_prev = tx_en;
    if (read_en) ra.push_back(int'(read_address));
    if (done) done_cnt++;
  end

  always @(negedge clk) begin
    if (bp_mode) begin
      if (tx_en) stall = 20;
      else if (stall > 0) stall--;
    end
  end

  function automatic logic [7:0] rxb(input int i);
    if (i < rx.size()) return rx[i];
    return 8'hxx;
  endfunction

  function automatic int rab(input int i);
    if (i < ra.size()) return ra[i];
    return -1;
  endfunction

  function automatic int first_bad(input int st);
    logic [7:0]  x;
    logic [7:0]  e;
    logic [11:0] v;
    x = 8'h00;
    for (int k = 0; k < NB; k++) begin
      if (k < 2 * DEPTH) begin
        v = ram[(st + k / 2) % DEPTH];
        e = (k % 2 == 0) ? {4'h0, v[11:8]} : v[7:0];
        x = x ^ e;
      end else begin
        e = x;
      end
      if (k >= rx.size()) return k;
      if (rx[k] !== e) return k;
    end
    if (rx.size() != NB) return NB;
    return -1;
  endfunction

  task automatic clear_logs();
    rx.delete();
    ra.delete();
    viol = 0;
    dup = 0;
  endtask

  task automatic pulse_start(input logic [AW-1:0] a);
    @(posedge clk); #1;
    start = 1'b1;
    start_addr = a;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget, output bit ok);
    int d0;
    d0 = done_cnt;
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(posedge clk); #1;
      if (done_cnt > d0) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    #12;
    chk_cnt++;
    if ({busy, tx_en, read_en, done, tx_data, read_address} !== '0)
      $display("FAIL reset_outputs: got %b/%b/%b/%b/%h/%h required all 0",
               busy, tx_en, read_en, done, tx_data, read_address);
    else pass_cnt++;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk_cnt++;
    if ({busy, tx_en, read_en} !== 3'b000)
      $display("FAIL idle_quiet: got %b%b%b required 000", busy, tx_en, read_en);
    else pass_cnt++;
  endtask

  task automatic test_linear();
    bit ok;
    int lat;
    int d0;
    int fb;
    for (int a = 0; a < DEPTH; a++) ram[a] = 12'(a);
    tb_ready = 1'b1;
    clear_logs();
    d0 = done_cnt;
    @(posedge clk); #1;
    start = 1'b1;
    start_addr = '0;
    lat = 0;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); #1;
      start = 1'b0;
      if (tx_en) begin
        lat = i;
        break;
      end
    end
    chk_cnt++;
    if (lat !== 4)
      $display("FAIL start_latency: got %0d required 4", lat);
    else pass_cnt++;
    wait_done(5000, ok);
    chk_cnt++;
    if (ok !== 1'b1) $display("FAIL linear_done: got timeout required done");
    else pass_cnt++;
    repeat (4) @(posedge clk);
    #1;
    fb = first_bad(0);
    chk_cnt++;
    if (fb !== -1)
      $display("FAIL linear_stream: first bad byte %0d of %0d required none", fb, rx.size());
    else pass_cnt++;
    chk_cnt++;
    if ({rxb(0), rxb(1), rxb(2), rxb(3)} !== 32'h0000_0001)
      $display("FAIL linear_head: got %h%h%h%h required 00000001",
               rxb(0), rxb(1), rxb(2), rxb(3));
    else pass_cnt++;
    chk_cnt++;
    if ({rxb(1022), rxb(1023)} !== 16'h01FF)
      $display("FAIL linear_tail: got %h%h required 01ff", rxb(1022), rxb(1023));
    else pass_cnt++;
    chk_cnt++;
    if (rx.size() !== NB)
      $display("FAIL linear_count: got %0d required %0d", rx.size(), NB);
    else pass_cnt++;
    chk_cnt++;
    if (done_cnt - d0 !== 1)
      $display("FAIL linear_done_pulses: got %0d required 1", done_cnt - d0);
    else pass_cnt++;
    chk_cnt++;
    if (busy !== 1'b0) $display("FAIL linear_busy_end: got %b required 0", busy);
    else pass_cnt++;
    chk_cnt++;
    if (dup !== 0) $display("FAIL linear_en_back2back: got %0d required 0", dup);
    else pass_cnt++;
  endtask

  task automatic test_wrap();
    bit ok;
    int fb;
    clear_logs();
    pulse_start(9'd510);
    wait_done(5000, ok);
    repeat (2) @(posedge clk);
    #1;
    chk_cnt++;
    if (ok !== 1'b1) $display("FAIL wrap_done: got timeout required done");
    else pass_cnt++;
    chk_cnt++;
    if ({rxb(0), rxb(1), rxb(2), rxb(3), rxb(4), rxb(5)} !== 48'h01FE_01FF_0000)
      $display("FAIL wrap_head: got %h%h%h%h%h%h required 01fe01ff0000",
               rxb(0), rxb(1), rxb(2), rxb(3), rxb(4), rxb(5));
    else pass_cnt++;
    fb = first_bad(510);
    chk_cnt++;
    if (fb !== -1) $display("FAIL wrap_stream: first bad byte %0d required none", fb);
    else pass_cnt++;
    chk_cnt++;
    if ({rab(0), rab(1), rab(2), rab(511)} !== {32'd510, 32'd511, 32'd0, 32'd509})
      $display("FAIL wrap_addrs: got %0d,%0d,%0d..%0d required 510,511,0..509",
               rab(0), rab(1), rab(2), rab(511));
    else pass_cnt++;
    chk_cnt++;
    if (ra.size() !== DEPTH)
      $display("FAIL wrap_reads: got %0d required %0d", ra.size(), DEPTH);
    else pass_cnt++;
  endtask

  task automatic test_backpressure();
    bit ok;
    int fb;
    clear_logs();
    bp_mode = 1'b1;
    pulse_start(9'd0);
    wait_done(40000, ok);
    repeat (2) @(posedge clk);
    #1;
    bp_mode = 1'b0;
    chk_cnt++;
    if (ok !== 1'b1) $display("FAIL bp_done: got timeout required done");
    else pass_cnt++;
    fb = first_bad(0);
    chk_cnt++;
    if (fb !== -1) $display("FAIL bp_stream: first bad byte %0d required none", fb);
    else pass_cnt++;
    chk_cnt++;
    if (viol !== 0) $display("FAIL bp_en_without_ready: got %0d required 0", viol);
    else pass_cnt++;
    chk_cnt++;
    if (dup !== 0) $display("FAIL bp_en_back2back: got %0d required 0", dup);
    else pass_cnt++;
  endtask

  task automatic test_start_ignored();
    bit ok;
    int d0;
    int fb;
    clear_logs();
    d0 = done_cnt;
    pulse_start(9'd0);
    for (int i = 0; i < 1000; i++) begin
      @(posedge clk); #1;
      if (rx.size() >= 100) break;
    end
    pulse_start(9'd100);
    chk_cnt++;
    if (busy !== 1'b1) $display("FAIL restart_busy: got %b required 1", busy);
    else pass_cnt++;
    wait_done(5000, ok);
    repeat (4) @(posedge clk);
    #1;
    fb = first_bad(0);
    chk_cnt++;
    if (fb !== -1) $display("FAIL restart_stream: first bad byte %0d required none", fb);
    else pass_cnt++;
    chk_cnt++;
    if (done_cnt - d0 !== 1)
      $display("FAIL restart_done_pulses: got %0d required 1", done_cnt - d0);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    bit ok;
    int fb;
    clear_logs();
    pulse_start(9'd260);
    for (int i = 0; i < 200; i++) begin
      @(posedge clk); #1;
      if (rx.size() >= 11) break;
    end
    tb_ready = 1'b0;
    chk_cnt++;
    if (tx_data !== 8'h01)
      $display("FAIL midrst_pre_byte: got %h required 01", tx_data);
    else pass_cnt++;
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk_cnt++;
    if ({busy, tx_en, read_en, done, tx_data, read_address} !== '0)
      $display("FAIL midrst_outputs: got %b/%b/%b/%b/%h/%h required all 0",
               busy, tx_en, read_en, done, tx_data, read_address);
    else pass_cnt++;
    @(posedge clk); #1;
    rst_n = 1'b1;
    clear_logs();
    tb_ready = 1'b1;
    pulse_start(9'd300);
    wait_done(5000, ok);
    repeat (2) @(posedge clk);
    #1;
    fb = first_bad(300);
    chk_cnt++;
    if (fb !== -1) $display("FAIL midrst_stream: first bad byte %0d required none", fb);
    else pass_cnt++;
    chk_cnt++;
    if (rab(0) !== 300) $display("FAIL midrst_addr: got %0d required 300", rab(0));
    else pass_cnt++;
  endtask

  task automatic test_checksum();
    bit ok;
    int fb;
    for (int a = 0; a < DEPTH; a++) ram[a] = 12'hABC;
    clear_logs();
    pulse_start(9'd0);
    wait_done(5000, ok);
    repeat (4) @(posedge clk);
    #1;
    chk_cnt++;
    if ({rxb(0), rxb(1), rxb(1022), rxb(1023)} !== 32'h0ABC_0ABC)
      $display("FAIL const_pairs: got %h%h..%h%h required 0abc..0abc",
               rxb(0), rxb(1), rxb(1022), rxb(1023));
    else pass_cnt++;
    chk_cnt++;
    if (rx.size() !== NB)
      $display("FAIL const_count: got %0d required %0d", rx.size(), NB);
    else pass_cnt++;
    fb = first_bad(0);
    chk_cnt++;
    if (fb !== -1) $display("FAIL const_stream: first bad byte %0d required none", fb);
    else pass_cnt++;
`ifdef CAPTURE_READOUT_CHECKSUM_EN
    chk_cnt++;
    if (rxb(1024) !== 8'h00)
      $display("FAIL checksum_byte: got %h required 00", rxb(1024));
    else pass_cnt++;
`endif
  endtask

  initial begin
    test_reset();
    test_linear();
    test_wrap();
    test_backpressure();
    test_start_ignored();
    test_reset_mid();
    test_checksum();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
